bus_io_responder: RTL and testbench
===================================

// Module: bus_io_responder
// PURPOSE
//  Memory-mapped I/O target on the CPU's 16-bit address bus and 8-bit shared data bus; the responder side of the CPU bus.
//  Exposes DATA/STATUS/CTRL registers at BASE_ADDR..BASE_ADDR+2.
//  DATA buffers bytes in an RX FIFO (device->CPU) and a TX FIFO (CPU->device).
//  Drives the shared bus only during a selected read; otherwise the bus is high-Z.
// PARAMETERS
//  BASE_ADDR   16'hF000  base of the 3-register window
//  FIFO_DEPTH  8         entries per FIFO; must be a power of two, >= 2
// PORTS
//  clk        in     1   system clock, rising-edge
//  reset      in     1   asynchronous, active-high
//  addr_bus   in     16  CPU address
//  bus        inout  8   shared data bus
//  mem_rd     in     1   CPU read strobe, active-high, may last >1 cycle
//  mem_wr     in     1   CPU write strobe, active-high, may last >1 cycle
//  rx_data    in     8   device byte into the RX FIFO
//  rx_valid   in     1   rx_data valid
//  rx_ready   out    1   RX FIFO not full
//  tx_data    out    8   TX FIFO head
//  tx_valid   out    1   TX FIFO not empty
//  tx_ready   in     1   device accepts tx_data
//  irq        out    1   only present with BUS_IO_IRQ_EN
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-high.
//  - Reset: both FIFOs are empty.
//    - Output values: rx_ready=1, tx_valid=0, tx_data=0, irq=0, bus=Z.
//    - Register state: overflow flag=0, CTRL=0, strobe-edge registers=0.
//  - Select: sel = addr_bus in [BASE_ADDR, BASE_ADDR+2]. Offset 3 and above is unselected.
//  - Read data: while sel & mem_rd, bus is driven combinationally from the addressed register, otherwise 8'bz.
//    - DATA returns the RX head, or 8'h00 if RX is empty.
//    - STATUS returns {3'b0, ovf, tx_full, tx_nempty, rx_full, rx_nempty}.
//    - CTRL reads back {6'b0, irq_en, 1'b0}.
//  - Strobe edges: mem_rd and mem_wr are registered each clock. Side effects fire only on the first clock where the strobe is 1 and its registered copy is 0.
//    - Exactly one pop or push per strobe, whatever the strobe length.
//    - If sel or offset changes while the strobe is held, no new edge occurs.
//  - Read of DATA (edge): pops RX. Popping an empty RX does nothing.
//  - Write of DATA (edge): pushes the bus byte into TX.
//    - If TX is full, the byte is dropped and ovf is set.
//  - Write of CTRL (edge):
//    - bit0=1 clears ovf.
//    - bit1=1 flushes both FIFOs.
//    - bit2 is stored as irq_en.
//  - Write of STATUS: ignored.
//  - mem_rd and mem_wr both 1: treated as a write. No read side effect and the bus stays Z.
//  - Device RX push: on rx_valid & rx_ready.
//    - rx_valid while full: the byte is dropped and ovf is set.
//  - Device TX pop: on tx_valid & tx_ready.
//  - Simultaneous events on the same FIFO:
//    - Push and pop in the same cycle both take effect. Occupancy is unchanged, including when full.
//    - A full-FIFO push with a same-cycle pop is accepted and does not set ovf.
//    - Flush has priority over a same-cycle push or pop.
//  - Latency:
//    - A pushed byte is visible at the head one clock after the push edge.
//    - STATUS reflects an event the clock after it occurs.
//  - Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty.
//  - Reset mid-transfer: state clears immediately and bus goes Z. A strobe still high after reset deasserts produces no edge.
// CONFIGURATION
//  - BUS_IO_IRQ_EN defined:
//    - irq port exists, registered: irq = irq_en & (rx_nempty | ovf).
//    - irq is updated on the clock after the condition changes.
//  - BUS_IO_IRQ_EN undefined:
//    - No irq port; CTRL bit2 is not stored and reads back 0.
// STRUCTURE
//  - Shared include defs/bus_io_defs.v holds:
//    - register offsets: OFS_DATA=0, OFS_STATUS=1, OFS_CTRL=2
//    - STATUS bit indices
//    - CTRL bit indices
//  - Sub-module byte_fifo(WIDTH=8, DEPTH), instantiated twice (RX, TX):
//    - ports: push, pop, flush, din, dout, empty, full
//    - head data shown combinationally
//  - Top level holds the decode, strobe edge detectors, ovf/CTRL registers, tristate drive and irq.
// TESTING
//  1. Push 8'hA5 via rx_valid, then assert mem_rd at F000 for 3 cycles -> bus=A5 throughout; exactly one pop; STATUS then reads 8'h00.
//  2. Write 9 bytes to F000 with tx_ready=0 -> tx_full=1, 9th byte dropped, STATUS=8'h1C; write F002=8'h01 -> ovf=0.
//  3. RX full and rx_valid=1, CPU DATA-read edge in the same cycle -> byte accepted, rx_full stays 1, ovf stays 0.
//  4. 20 push/pop pairs through TX (pointer wrap) -> tx_data is the in-order sequence 00..13, no loss.
//  5. Reset asserted mid mem_rd with RX holding 3 bytes -> bus Z at once, RX empty; strobe held after release causes no pop.
//  6. With BUS_IO_IRQ_EN: write F002=8'h04, then push one RX byte -> irq=1 the next clock; read DATA -> irq=0 the clock after the pop.

Source files
------------

// File: rtl/bus_io_responder_pkg.sv
// Register map and field layout shared by the bus_io_responder files.
package bus_io_responder_pkg;

   typedef enum logic [1:0] {
      OFS_DATA   = 2'd0,
      OFS_STATUS = 2'd1,
      OFS_CTRL   = 2'd2,
      OFS_NONE   = 2'd3
   } reg_ofs_e;

   typedef struct packed {
      logic [2:0] rsvd;
      logic       ovf;
      logic       tx_full;
      logic       tx_nempty;
      logic       rx_full;
      logic       rx_nempty;
   } status_t;

   // Bit positions in a CTRL write; irq_en reads back one place lower.
   localparam int CTRL_CLR_OVF   = 0;
   localparam int CTRL_FLUSH     = 1;
   localparam int CTRL_IRQ_EN    = 2;
   localparam int CTRL_RB_IRQ_EN = 1;

endpackage

// File: rtl/bus_io_responder_fifo.sv
// Synchronous byte FIFO with flush; head shown combinationally, zero when empty.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop frees the slot a same-cycle push into a full FIFO needs.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the empty gate on dout keeps stale entries invisible.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/bus_io_responder.sv
// Memory-mapped DATA/STATUS/CTRL responder with RX/TX byte FIFOs on a shared tristate bus.
// Optional irq output and CTRL irq_en bit are built when BUS_IO_IRQ_EN is defined.
module bus_io_responder
   import bus_io_responder_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hF000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_bus,
   inout  wire  [7:0]  bus,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
`ifdef BUS_IO_IRQ_EN
   ,
   output logic        irq
`endif
);

   logic [15:0] ofs_full;
   logic        sel;
   reg_ofs_e    ofs;
   logic        rd_q, wr_q, rd_arm_q, wr_arm_q;
   logic        rd_edge, wr_edge;
   logic        rx_pop, tx_push, tx_pop, ctrl_wr, flush;
   logic        rx_empty, rx_full, tx_empty, tx_full;
   logic [7:0]  rx_dout;
   logic        ovf_q, ovf_d, rx_drop, tx_drop;
   logic [7:0]  rd_hold_q;
   logic        rd_hold_vld_q;
   logic        irq_en;
   status_t     status;
   logic [7:0]  rd_data;
   logic        bus_oe;

   // Addresses below the base wrap to large offsets, so one compare decodes the window.
   assign ofs_full = addr_bus - BASE_ADDR;
   assign sel      = (ofs_full < 16'd3);
   assign ofs      = reg_ofs_e'(ofs_full[1:0]);

   // Arm flags keep a strobe already high when reset releases from forming an edge.
   assign rd_edge = mem_rd & ~mem_wr & ~rd_q & rd_arm_q;
   assign wr_edge = mem_wr & ~wr_q & wr_arm_q;

   assign rx_pop  = rd_edge & sel & (ofs == OFS_DATA);
   assign tx_push = wr_edge & sel & (ofs == OFS_DATA);
   assign ctrl_wr = wr_edge & sel & (ofs == OFS_CTRL);
   assign flush   = ctrl_wr & bus[CTRL_FLUSH];
   assign tx_pop  = tx_ready & tx_valid;

   assign rx_drop = rx_valid & rx_full & ~rx_pop & ~flush;
   assign tx_drop = tx_push & tx_full & ~tx_pop;
   assign ovf_d   = (ovf_q & ~(ctrl_wr & bus[CTRL_CLR_OVF])) | rx_drop | tx_drop;

   byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_valid),
      .pop   (rx_pop),
      .flush (flush),
      .din   (rx_data),
      .dout  (rx_dout),
      .empty (rx_empty),
      .full  (rx_full)
   );

   byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_ready),
      .flush (flush),
      .din   (bus),
      .dout  (tx_data),
      .empty (tx_empty),
      .full  (tx_full)
   );

   assign rx_ready = ~rx_full;
   assign tx_valid = ~tx_empty;

   // A held DATA read keeps showing the byte its edge popped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         rd_arm_q      <= 1'b0;
         wr_arm_q      <= 1'b0;
         ovf_q         <= 1'b0;
         rd_hold_q     <= 8'h00;
         rd_hold_vld_q <= 1'b0;
      end else begin
         rd_q          <= mem_rd;
         wr_q          <= mem_wr;
         rd_arm_q      <= rd_arm_q | ~mem_rd;
         wr_arm_q      <= wr_arm_q | ~mem_wr;
         ovf_q         <= ovf_d;
         rd_hold_vld_q <= rx_pop | (rd_hold_vld_q & mem_rd);
         if (rx_pop) rd_hold_q <= rx_dout;
      end
   end

`ifdef BUS_IO_IRQ_EN
   logic irq_en_q, irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en_q <= bus[CTRL_IRQ_EN];
         irq_q <= irq_en_q & (~rx_empty | ovf_q);
      end
   end

   assign irq_en = irq_en_q;
   assign irq    = irq_q;
`else
   assign irq_en = 1'b0;
`endif

   always_comb begin
      status           = '0;
      status.ovf       = ovf_q;
      status.tx_full   = tx_full;
      status.tx_nempty = ~tx_empty;
      status.rx_full   = rx_full;
      status.rx_nempty = ~rx_empty;
   end

   always_comb begin
      rd_data = 8'h00;
      case (ofs)
         OFS_DATA:   rd_data = rd_hold_vld_q ? rd_hold_q : rx_dout;
         OFS_STATUS: rd_data = status;
         OFS_CTRL:   rd_data[CTRL_RB_IRQ_EN] = irq_en;
         default:    rd_data = 8'h00;
      endcase
   end

   assign bus_oe = sel & mem_rd & ~mem_wr & ~reset;
   assign bus    = bus_oe ? rd_data : 8'bz;

endmodule

// File: tb/tb_bus_io_responder.sv
// Directed bench for bus_io_responder: register table plus multi-cycle corner sequences.
module tb_bus_io_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr_bus;
   wire  [7:0]  bus;
   logic        mem_rd, mem_wr;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tb_oe;
   logic [7:0]  tb_dout;
`ifdef BUS_IO_IRQ_EN
   logic        irq;
   localparam logic [7:0] IRQ_RB = 8'h02;
`else
   localparam logic [7:0] IRQ_RB = 8'h00;
`endif

   assign bus = tb_oe ? tb_dout : 8'bz;

   bus_io_responder dut (
      .clk      (clk),
      .reset    (reset),
      .addr_bus (addr_bus),
      .bus      (bus),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
`ifdef BUS_IO_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  data;
      string       name;
   } vec_t;

   int   n_total = 0;
   int   n_pass  = 0;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      addr_bus = a;
      tb_dout  = d;
      tb_oe    = 1'b1;
      mem_wr   = 1'b1;
      tick();
      mem_wr   = 1'b0;
      tb_oe    = 1'b0;
      tick();
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
      addr_bus = a;
      mem_rd   = 1'b1;
      #2 d     = bus;
      tick();
      mem_rd   = 1'b0;
      tick();
   endtask

   function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [7:0] d,
                               input string n);
      vec_t v;
      v.wr   = wr;
      v.addr = a;
      v.data = d;
      v.name = n;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;

      vecs[0]  = mk(1'b0, 16'hF001, 8'h00, "status_after_reset");
      vecs[1]  = mk(1'b1, 16'hF000, 8'h11, "wr_data");
      vecs[2]  = mk(1'b0, 16'hF001, 8'h04, "status_tx_nempty");
      vecs[3]  = mk(1'b1, 16'hF001, 8'hFF, "wr_status");
      vecs[4]  = mk(1'b0, 16'hF001, 8'h04, "status_write_ignored");
      vecs[5]  = mk(1'b1, 16'hF002, 8'h04, "wr_ctrl_irq_en");
      vecs[6]  = mk(1'b0, 16'hF002, IRQ_RB, "ctrl_readback");
      vecs[7]  = mk(1'b0, 16'hF000, 8'h00, "data_rx_empty");
      vecs[8]  = mk(1'b1, 16'hF002, 8'h02, "wr_ctrl_flush");
      vecs[9]  = mk(1'b0, 16'hF001, 8'h00, "status_after_flush");
      vecs[10] = mk(1'b1, 16'hF002, 8'h00, "wr_ctrl_zero");
      vecs[11] = mk(1'b0, 16'hF002, 8'h00, "ctrl_cleared");

      reset    = 1'b1;
      addr_bus = 16'h0000;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      tb_oe    = 1'b0;
      tb_dout  = 8'h00;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      check("reset_rx_ready", rx_ready, 1);
      check("reset_tx_valid", tx_valid, 0);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_bus_z", dut.bus_oe, 0);
`ifdef BUS_IO_IRQ_EN
      check("reset_irq", irq, 0);
`endif

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
         else begin
            bus_rd(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].data);
         end
      end

      // Read and write together behave as a write and leave the bus undriven.
      addr_bus = 16'hF000;
      tb_dout  = 8'h77;
      tb_oe    = 1'b1;
      mem_rd   = 1'b1;
      mem_wr   = 1'b1;
      #2 check("rdwr_bus_z", dut.bus_oe, 0);
      tick();
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      tb_oe  = 1'b0;
      check("rdwr_pushed_tx_data", tx_data, 8'h77);
      check("rdwr_pushed_tx_valid", tx_valid, 1);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("tx_drained", tx_valid, 0);

      // Window edges.
      bus_wr(16'hF003, 8'h55);
      check("wr_unselected_no_push", tx_valid, 0);
      addr_bus = 16'hF003;
      mem_rd   = 1'b1;
      #1 check("rd_f003_bus_z", dut.bus_oe, 0);
      addr_bus = 16'hEFFF;
      #1 check("rd_efff_bus_z", dut.bus_oe, 0);
      addr_bus = 16'hF002;
      #1 check("rd_f002_driven", dut.bus_oe, 1);
      tick();
      mem_rd = 1'b0;
      tick();

      // Held DATA read: one pop, stable byte for the whole strobe.
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      tick();
      rx_data  = 8'h3C;
      tick();
      rx_valid = 1'b0;
      addr_bus = 16'hF000;
      mem_rd   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2 check("held_read_bus", bus, 8'hA5);
         tick();
      end
      mem_rd = 1'b0;
      tick();
      bus_rd(16'hF000, rd);
      check("single_pop_next_head", rd, 8'h3C);
      bus_rd(16'hF001, rd);
      check("status_after_pops", rd, 8'h00);

      // TX overflow then clear.
      for (int i = 1; i <= 9; i++) bus_wr(16'hF000, 8'(i));
      bus_rd(16'hF001, rd);
      check("status_tx_ovf", rd, 8'h1C);
      check("tx_head_first_byte", tx_data, 8'h01);
      bus_wr(16'hF002, 8'h01);
      bus_rd(16'hF001, rd);
      check("status_ovf_cleared", rd, 8'h0C);
      bus_wr(16'hF002, 8'h02);

      // RX full with a same-cycle device push and CPU pop.
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rx_data = 8'h10 + 8'(i);
         tick();
      end
      rx_valid = 1'b0;
      check("rx_full_not_ready", rx_ready, 0);
      bus_rd(16'hF001, rd);
      check("status_rx_full", rd, 8'h03);
      addr_bus = 16'hF000;
      mem_rd   = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h18;
      #2 check("full_pop_head", bus, 8'h10);
      tick();
      mem_rd   = 1'b0;
      rx_valid = 1'b0;
      tick();
      bus_rd(16'hF001, rd);
      check("status_full_no_ovf", rd, 8'h03);
      for (int i = 0; i < 8; i++) begin
         bus_rd(16'hF000, rd);
         check("rx_drain_order", rd, 8'h11 + 8'(i));
      end

      // TX pointer wrap with the device draining each byte.
      tx_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         addr_bus = 16'hF000;
         tb_dout  = 8'(i);
         tb_oe    = 1'b1;
         mem_wr   = 1'b1;
         tick();
         check("tx_wrap_seq", tx_data, 8'(i));
         mem_wr = 1'b0;
         tb_oe  = 1'b0;
         tick();
      end
      check("tx_wrap_empty", tx_valid, 0);
      tx_ready = 1'b0;

      // Reset in the middle of a held DATA read.
      rx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_data = 8'h21 + 8'(i);
         tick();
      end
      rx_valid = 1'b0;
      addr_bus = 16'hF000;
      mem_rd   = 1'b1;
      tick();
      reset = 1'b1;
      #1 check("reset_mid_read_bus_z", dut.bus_oe, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_rx_empty", bus, 8'h00);
      check("post_reset_driven", dut.bus_oe, 1);
      rx_valid = 1'b1;
      rx_data  = 8'h44;
      tick();
      rx_valid = 1'b0;
      tick();
      tick();
      check("held_strobe_no_pop", bus, 8'h44);
      mem_rd = 1'b0;
      tick();
      bus_rd(16'hF001, rd);
      check("status_byte_kept", rd, 8'h01);
      bus_rd(16'hF000, rd);
      check("pop_after_release", rd, 8'h44);

`ifdef BUS_IO_IRQ_EN
      bus_wr(16'hF002, 8'h04);
      check("irq_idle", irq, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h66;
      tick();
      rx_valid = 1'b0;
      check("irq_not_yet", irq, 0);
      tick();
      check("irq_set", irq, 1);
      addr_bus = 16'hF000;
      mem_rd   = 1'b1;
      tick();
      check("irq_held_at_pop", irq, 1);
      mem_rd = 1'b0;
      tick();
      check("irq_cleared", irq, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
